// File: rtl/line_tx_sched_if.sv
// Line-buffer read bus plus the outbound valid/ready byte stream of the capture scheduler.
interface line_tx_sched_if;
    logic        lb_trig;
    logic        lb_busy;
    logic        lb_aquire;
    logic        lb_read_en;
    logic [7:0]  lb_data;
    logic [10:0] lb_row;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_last;

    modport master (
        output lb_trig, lb_read_en, tx_valid, tx_data, tx_last,
        input  lb_busy, lb_aquire, lb_data, lb_row, tx_ready
    );

    modport slave (
        input  lb_trig, lb_read_en, tx_valid, tx_data, tx_last,
        output lb_busy, lb_aquire, lb_data, lb_row, tx_ready
    );
endinterface

// File: rtl/line_tx_sched.sv
// Arms a line_buffer capture, drains it row by row and frames each row as a header+payload packet
// on a byte stream; a 4-entry skid FIFO with read credits absorbs sink backpressure.
module line_tx_sched #(
    parameter int ROW_BYTES  = 1280,
    parameter int FRAME_ROWS = 1440,
    parameter int TIMEOUT    = 1000000
) (
    input  logic            rclk,
    input  logic            rstn,
    input  logic            start,
    line_tx_sched_if.master bus,
    output logic            done,
    output logic            timeout,
    output logic            busy
);
    localparam int                WAIT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIM   = WAIT_W'(TIMEOUT - 1);
    localparam logic [10:0]       ROW_LIM    = 11'(ROW_BYTES);
    localparam logic [10:0]       ROW_LAST   = 11'(ROW_BYTES - 1);
    localparam logic [10:0]       FRAME_LAST = 11'(FRAME_ROWS - 1);

    typedef enum logic [2:0] {IDLE, ARM, HDR, PAYLOAD, FINISH, ABORT} state_t;

    state_t            state, state_nxt;
    logic [7:0]        skid_mem [4];
    logic [1:0]        wr_ptr, rd_ptr;
    logic [2:0]        count;
    logic              vld_p1;
    logic [10:0]       issued, sent, rows, row_q;
    logic [1:0]        hdr_idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              trig_q, done_q, timeout_q;

    logic              read_en, tx_valid_c, tx_last_c, xfer, wait_hit;
    logic              skid_push, skid_pop, row_load;
    logic [7:0]        tx_data_c, hdr_byte;

    always_comb begin
        case (hdr_idx)
            2'd0:    hdr_byte = 8'hA5;
            2'd1:    hdr_byte = 8'h5A;
            2'd2:    hdr_byte = {5'b0, row_q[10:8]};
            default: hdr_byte = row_q[7:0];
        endcase
    end

    always_comb begin
        state_nxt  = state;
        read_en    = 1'b0;
        tx_valid_c = 1'b0;
        tx_data_c  = 8'h00;
        tx_last_c  = 1'b0;
        wait_hit   = (wait_cnt >= WAIT_LIM);
        case (state)
            IDLE: if (start) state_nxt = ARM;
            ARM: begin
                if (bus.lb_busy)   state_nxt = HDR;
                else if (wait_hit) state_nxt = ABORT;
            end
            HDR: begin
                tx_valid_c = 1'b1;
                tx_data_c  = hdr_byte;
                if (bus.tx_ready && hdr_idx == 2'd3) state_nxt = PAYLOAD;
            end
            PAYLOAD: begin
                // A read is only issued when the skid has room for it plus the byte still in flight.
                read_en    = bus.lb_aquire && (({1'b0, count} + {3'b0, vld_p1}) < 4'd4) &&
                             (issued < ROW_LIM);
                tx_valid_c = (count != 3'd0);
                tx_data_c  = tx_valid_c ? skid_mem[rd_ptr] : 8'h00;
                tx_last_c  = tx_valid_c && (sent == ROW_LAST);
                if (tx_valid_c && bus.tx_ready && tx_last_c)
                    state_nxt = (rows == FRAME_LAST) ? FINISH : HDR;
                else if (!bus.lb_aquire && wait_hit)
                    state_nxt = ABORT;
            end
            FINISH: begin
                if (!bus.lb_busy)  state_nxt = IDLE;
                else if (wait_hit) state_nxt = ABORT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign xfer      = tx_valid_c && bus.tx_ready;
    assign skid_push = vld_p1 && (state != ABORT);
    assign skid_pop  = (state == PAYLOAD) && xfer;
    assign row_load  = (state_nxt == HDR) && (state != HDR);

    always_ff @(posedge rclk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            trig_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            vld_p1    <= 1'b0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            count     <= 3'd0;
            issued    <= 11'd0;
            sent      <= 11'd0;
            rows      <= 11'd0;
            hdr_idx   <= 2'd0;
            wait_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            trig_q    <= (state == IDLE) && start;
            done_q    <= (state == FINISH) && !bus.lb_busy;
            timeout_q <= (state_nxt == ABORT);
            // Stage p1: read issued last cycle, its byte lands in the skid this cycle.
            vld_p1    <= read_en;
            if (state == ABORT) begin
                wr_ptr <= 2'd0;
                rd_ptr <= 2'd0;
                count  <= 3'd0;
            end else begin
                if (skid_push) wr_ptr <= wr_ptr + 2'd1;
                if (skid_pop)  rd_ptr <= rd_ptr + 2'd1;
                count <= count + {2'b0, skid_push} - {2'b0, skid_pop};
            end
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    rows     <= 11'd0;
                    hdr_idx  <= 2'd0;
                end
                ARM: wait_cnt <= wait_cnt + WAIT_W'(1);
                HDR: begin
                    if (xfer) begin
                        hdr_idx <= hdr_idx + 2'd1;
                        if (hdr_idx == 2'd3) begin
                            issued   <= 11'd0;
                            sent     <= 11'd0;
                            wait_cnt <= '0;
                        end
                    end
                end
                PAYLOAD: begin
                    if (read_en) begin
                        issued   <= issued + 11'd1;
                        wait_cnt <= '0;
                    end else if (!bus.lb_aquire) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                    if (xfer && sent != ROW_LIM) sent <= sent + 11'd1;
                    if (xfer && tx_last_c) begin
                        rows     <= rows + 11'd1;
                        wait_cnt <= '0;
                    end
                end
                FINISH:  wait_cnt <= wait_cnt + WAIT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge rclk) begin
        if (skid_push) skid_mem[wr_ptr] <= bus.lb_data;
        if (row_load)  row_q <= bus.lb_row;
    end

    assign bus.lb_trig    = trig_q;
    assign bus.lb_read_en = read_en;
    assign bus.tx_valid   = tx_valid_c;
    assign bus.tx_data    = tx_data_c;
    assign bus.tx_last    = tx_last_c;
    assign done           = done_q;
    assign timeout        = timeout_q;
    assign busy           = (state != IDLE);
endmodule
